// File: rtl/golden_nonce_fifo.sv
// Arrival-ordered golden-nonce queue fed by the even/odd hashcores, with
// latest/previous snapshots for the legacy readout frame and drop accounting.
module golden_nonce_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       hash_clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       match_1,
  input  logic [WIDTH-1:0]           nonce_1,
  input  logic                       match_2,
  input  logic [WIDTH-1:0]           nonce_2,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           latest,
  output logic [WIDTH-1:0]           previous,
  output logic [7:0]                 drops,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      cnt;

  logic             pop_ok;
  logic [AW+1:0]    space;
  logic [1:0]       n_push;
  logic [1:0]       n_drop;
  logic [8:0]       drops_sum;

  // A pop in the same cycle frees its slot before the pushes are sized.
  always_comb begin
    pop_ok    = pop && (cnt != '0);
    space     = (AW+2)'(DEPTH) - {1'b0, cnt} + {{(AW+1){1'b0}}, pop_ok};
    n_push    = '0;
    n_drop    = '0;
    if (match_1 && match_2) begin
      if (space >= (AW+2)'(2)) begin
        n_push = 2'd2;
      end else if (space == (AW+2)'(1)) begin
        n_push = 2'd1;
        n_drop = 2'd1;
      end else begin
        n_drop = 2'd2;
      end
    end else if (match_1 || match_2) begin
      if (space != '0) n_push = 2'd1;
      else             n_drop = 2'd1;
    end
    drops_sum = {1'b0, drops} + {7'b0, n_drop};
  end

  always_ff @(posedge hash_clk) begin
    if (!clear) begin
      if (match_1 && (n_push != '0))
        mem[wr_ptr] <= nonce_1;
      if (match_1 && match_2 && (n_push == 2'd2))
        mem[wr_ptr + 1'b1] <= nonce_2;
      if (!match_1 && match_2 && (n_push != '0))
        mem[wr_ptr] <= nonce_2;
    end
  end

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      latest   <= '0;
      previous <= '0;
      drops    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      latest   <= '0;
      previous <= '0;
      drops    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      wr_ptr <= wr_ptr + AW'(n_push);
      cnt    <= cnt + (AW+1)'(n_push) - (AW+1)'(pop_ok);
      drops  <= drops_sum[8] ? 8'hFF : drops_sum[7:0];
      if (n_drop != '0) overflow <= 1'b1;
      if (match_1 && match_2) begin
        previous <= nonce_1;
        latest   <= nonce_2;
      end else if (match_1) begin
        previous <= latest;
        latest   <= nonce_1;
      end else if (match_2) begin
        previous <= latest;
        latest   <= nonce_2;
      end
    end
  end

  assign head  = (cnt != '0) ? mem[rd_ptr] : '0;
  assign valid = (cnt != '0);
  assign count = cnt;

endmodule

// File: tb/tb_golden_nonce_fifo.sv
// Directed bench for golden_nonce_fifo: queue-based reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_golden_nonce_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 32;

  logic              hash_clk = 1'b0;
  logic              reset    = 1'b1;
  logic              clear    = 1'b0;
  logic              match_1  = 1'b0;
  logic [WIDTH-1:0]  nonce_1  = '0;
  logic              match_2  = 1'b0;
  logic [WIDTH-1:0]  nonce_2  = '0;
  logic              pop      = 1'b0;
  logic [WIDTH-1:0]  head;
  logic              valid;
  logic [3:0]        count;
  logic [WIDTH-1:0]  latest;
  logic [WIDTH-1:0]  previous;
  logic [7:0]        drops;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  golden_nonce_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .hash_clk(hash_clk), .reset(reset), .clear(clear),
    .match_1(match_1), .nonce_1(nonce_1),
    .match_2(match_2), .nonce_2(nonce_2),
    .pop(pop), .head(head), .valid(valid), .count(count),
    .latest(latest), .previous(previous), .drops(drops), .overflow(overflow)
  );

  always #5 hash_clk = ~hash_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus counters.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_latest, m_prev;
  int               m_drops;
  logic             m_ovf;

  task automatic model_clear();
    q.delete();
    m_latest = '0;
    m_prev   = '0;
    m_drops  = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_offer(input logic [WIDTH-1:0] n);
    if (q.size() < DEPTH) q.push_back(n);
    else begin
      m_drops = (m_drops >= 255) ? 255 : m_drops + 1;
      m_ovf   = 1'b1;
    end
  endtask

  always @(posedge hash_clk or posedge reset) begin
    if (reset || clear) model_clear();
    else begin
      if (pop && q.size() > 0) q.delete(0);
      if (match_1 && match_2) begin
        m_prev = nonce_1; m_latest = nonce_2;
      end else if (match_1) begin
        m_prev = m_latest; m_latest = nonce_1;
      end else if (match_2) begin
        m_prev = m_latest; m_latest = nonce_2;
      end
      if (match_1) model_offer(nonce_1);
      if (match_2) model_offer(nonce_2);
    end
  end

  always @(negedge hash_clk) begin
    check("head",     head,          (q.size() > 0) ? q[0] : 32'h0);
    check("valid",    32'(valid),    32'(q.size() > 0));
    check("count",    32'(count),    32'(q.size()));
    check("latest",   latest,        m_latest);
    check("previous", previous,      m_prev);
    check("drops",    32'(drops),    32'(m_drops));
    check("overflow", 32'(overflow), 32'(m_ovf));
  end

  task automatic cyc(input logic m1, input logic [31:0] n1, input logic m2,
                     input logic [31:0] n2, input logic p, input logic c);
    @(negedge hash_clk);
    match_1 = m1; nonce_1 = n1; match_2 = m2; nonce_2 = n2; pop = p; clear = c;
    @(posedge hash_clk);
    #2;
  endtask

  task automatic idle();
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic push1(input logic [31:0] n);
    cyc(1'b1, n, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    cyc(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_head"},  head, 0);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_latest"}, latest, 0);
    check({tag, "_prev"},  previous, 0);
    check({tag, "_drops"}, 32'(drops), 0);
    check({tag, "_ovf"},   32'(overflow), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge hash_clk);
    #2;
    check_zero("rst");
    @(negedge hash_clk);
    reset = 1'b0;

    // single push then pop
    push1(32'h00468bb4);
    check("p1_head", head, 32'h00468bb4);
    check("p1_valid", 32'(valid), 1);
    check("p1_count", 32'(count), 1);
    check("p1_latest", latest, 32'h00468bb4);
    check("p1_prev", previous, 0);
    pop1();
    check("p1_pop_valid", 32'(valid), 0);
    check("p1_pop_head", head, 0);
    check("p1_pop_count", 32'(count), 0);

    // dual push ordering
    cyc(1'b1, 32'h10, 1'b1, 32'h11, 1'b0, 1'b0);
    check("dual_count", 32'(count), 2);
    check("dual_head", head, 32'h10);
    check("dual_latest", latest, 32'h11);
    check("dual_prev", previous, 32'h10);
    pop1();
    check("dual_head2", head, 32'h11);
    pop1();

    // fill, overflow by one, drain in order (alternating cores)
    for (int i = 1; i <= 8; i++) begin
      if (i % 2 == 1) push1(32'(i));
      else cyc(1'b0, 0, 1'b1, 32'(i), 1'b0, 1'b0);
    end
    check("full_count", 32'(count), 8);
    push1(32'h9);
    check("ovf_drops", 32'(drops), 1);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_latest", latest, 32'h9);
    check("ovf_count", 32'(count), 8);
    for (int i = 1; i <= 8; i++) begin
      check("drain_head", head, 32'(i));
      pop1();
    end
    check("drain_count", 32'(count), 0);

    // full + pop + dual: first stored, second dropped
    for (int i = 1; i <= 8; i++) push1(32'h20 + 32'(i));
    cyc(1'b1, 32'hA, 1'b1, 32'hB, 1'b1, 1'b0);
    check("pd_count", 32'(count), 8);
    check("pd_drops", 32'(drops), 2);
    check("pd_head", head, 32'h22);
    check("pd_latest", latest, 32'hB);
    check("pd_prev", previous, 32'hA);
    repeat (8) pop1();
    check("pd_empty", 32'(valid), 0);

    // wrap-around with a pop every cycle
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 32'(100 + i), 1'b0, 0, 1'b1, 1'b0);
      check("wrap_head", head, 32'(100 + i));
      check("wrap_count_le1", 32'(count <= 4'd1), 1);
    end
    pop1();

    // clear with count=5, drops=3 and simultaneous strobes
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    check_zero("clr0");
    for (int i = 0; i < 8; i++) push1(32'h300 + 32'(i));
    repeat (3) push1(32'h3FF);
    repeat (3) pop1();
    check("pre_clr_count", 32'(count), 5);
    check("pre_clr_drops", 32'(drops), 3);
    cyc(1'b1, 32'h55, 1'b1, 32'h66, 1'b1, 1'b1);
    check_zero("clr");
    idle();
    check_zero("clr_idle");

    // async reset mid-burst
    push1(32'h501);
    cyc(1'b1, 32'h502, 1'b1, 32'h503, 1'b0, 1'b0);
    check("burst_count", 32'(count), 3);
    @(negedge hash_clk);
    match_1 = 1'b1; nonce_1 = 32'h504; match_2 = 1'b0; pop = 1'b0; clear = 1'b0;
    @(posedge hash_clk);
    #2;
    reset = 1'b1;
    #1;
    check_zero("arst");
    @(negedge hash_clk);
    match_1 = 1'b0;
    reset = 1'b0;
    idle();
    check_zero("arst_after");

    // drop saturation: 300 drops while full
    for (int i = 0; i < 8; i++) push1(32'h700 + 32'(i));
    for (int i = 0; i < 150; i++) cyc(1'b1, 32'h800, 1'b1, 32'h801, 1'b0, 1'b0);
    check("sat_drops", 32'(drops), 255);
    check("sat_ovf", 32'(overflow), 1);
    check("sat_count", 32'(count), 8);
    check("sat_head", head, 32'h700);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/golden_nonce_fifo.md
Name: golden_nonce_fifo

Overview:
- Collects golden-nonce reports from the two hashcore instances (even-nonce core and odd-nonce core) and queues them in arrival order for host readout.
- Replaces the two-deep golden_nonce_a/golden_nonce_b shift pair, so bursts of matches are no longer silently overwritten.
- Sits between the hashcore outputs and the host output-buffer loader.
- Also provides a latest/previous snapshot pair so the existing 128-bit readout frame can still be built.

Parameters:
- DEPTH, 8: number of FIFO entries; must be a power of 2 and at least 4.
- WIDTH, 32: nonce width in bits.

Ports:
- hash_clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clear  in  1  synchronous clear (host reset_buf); same effect as reset, applied at the clock edge.
- match_1  in  1  golden-nonce strobe from core 1 (even nonces), one cycle per match.
- nonce_1  in  WIDTH  nonce accompanying match_1.
- match_2  in  1  golden-nonce strobe from core 2 (odd nonces).
- nonce_2  in  WIDTH  nonce accompanying match_2.
- pop  in  1  host consumes the head entry.
- head  out  WIDTH  oldest queued nonce; 0 when empty.
- valid  out  1  FIFO non-empty.
- count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- latest  out  WIDTH  most recent golden nonce, replaces golden_nonce_a.
- previous  out  WIDTH  nonce before latest, replaces golden_nonce_b.
- drops  out  8  count of matches lost to a full FIFO; saturates at 255.
- overflow  out  1  sticky; set by the first drop.

Behaviour:
- Reset and clear: all outputs 0 and all pointers 0. Mid-cycle reset assertion aborts everything, including any pending push or pop.
- clear has priority over match and pop in the same cycle; strobes arriving in that cycle are discarded and are not counted as drops.
- Storage:
  - Circular buffer with rd_ptr/wr_ptr of log2(DEPTH) bits, wrapping modulo DEPTH, plus a separate count register.
  - head is driven combinationally from mem[rd_ptr], gated to 0 when count==0.
- Pop:
  - Honoured only when count>0; a pop while empty is ignored with no underflow.
  - Advances rd_ptr by 1.
- Push (up to two entries per cycle):
  - Effective space = DEPTH - count + (pop honoured ? 1 : 0). A pop in the same cycle frees its slot first.
  - match_1 only: write nonce_1 if space>=1, else drop.
  - match_2 only: write nonce_2 if space>=1, else drop.
  - Both, with space>=2: write nonce_1 at wr_ptr and nonce_2 at wr_ptr+1; wr_ptr advances by 2.
  - Both, with space==1: write nonce_1, drop nonce_2.
  - Both, with space==0: drop both; drops increases by 2 (saturating).
- count update: count_next = count + pushes - pops. It never exceeds DEPTH.
- Latency: a nonce pushed at edge N gives valid=1 and head=nonce after edge N. It can be popped at edge N+1 at the earliest.
- Drops: drops += number dropped, saturating at 255. overflow is set when any drop occurs and cleared only by reset or clear.
- Snapshots (update whether or not the FIFO is full):
  - Single match: previous <= latest, latest <= that nonce.
  - Dual match: previous <= nonce_1, latest <= nonce_2 (core 2 wins, matching the existing priority).
- Ordering: strict arrival order. Within one cycle, the core 1 nonce always precedes the core 2 nonce.
- No combinational path from the match/nonce inputs to any output.

Test Plan:
- Reset, then match_1 with nonce_1=32'h00468bb4 -> next cycle: valid=1, head=00468bb4, count=1, latest=00468bb4, previous=0. Pop -> valid=0, head=0, count=0.
- Same-cycle match_1=32'h10 and match_2=32'h11 -> count=2, head=10; after pop head=11; latest=11, previous=10.
- Push 8 single nonces 1..8 -> count=8. Then match_1=9 -> drops=1, overflow=1, latest=9, count=8. Pop 8 times -> heads 1..8 in order.
- With count=8, pop together with a dual match A/B -> A stored, B dropped, count=8, drops increments by 1.
- Wrap-around: 20 push/pop cycles with values 100..119 and a pop each cycle -> every head equals its pushed value; count stays at or below 1.
- Assert clear with count=5, drops=3 and a simultaneous match -> all outputs 0 next cycle. Asynchronous reset mid-burst -> outputs 0 immediately, before the next edge.
- 300 drops while full -> drops saturates at 255 and overflow stays 1.
